// File: rtl/riscv_trace_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_trace_pkg
// Description : Shared trace record type, access-size codes and mask helper.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_trace_pkg;

    localparam int c_trace_xlen = 32;

    localparam logic [1:0] c_size_byte  = 2'd0;
    localparam logic [1:0] c_size_half  = 2'd1;
    localparam logic [1:0] c_size_word  = 2'd2;
    localparam logic [1:0] c_size_dword = 2'd3;

    typedef struct packed {
        logic [31:0]                 instr;
        logic                        trap;
        logic [c_trace_xlen-1:0]     pc;
        logic [4:0]                  rd_addr;
        logic [c_trace_xlen-1:0]     rd_wdata;
        logic [c_trace_xlen-1:0]     mem_addr;
        logic [c_trace_xlen/8-1:0]   mem_rmask;
        logic [c_trace_xlen/8-1:0]   mem_wmask;
        logic [c_trace_xlen-1:0]     mem_data;
        logic [63:0]                 order;
    } trace_rec_t;

    // Byte-lane mask for a load; lanes pushed past bit 7 fall off the top.
    function automatic logic [7:0] size_to_mask(input logic [1:0] size,
                                                input logic [2:0] addr_lo);
        logic [7:0] base;
        case (size)
            c_size_byte:  base = 8'h01;
            c_size_half:  base = 8'h03;
            c_size_word:  base = 8'h0F;
            default:      base = 8'hFF;
        endcase
        return base << addr_lo;
    endfunction

endpackage
`default_nettype wire

// File: rtl/riscv_trace_fifo.sv
`default_nettype none
// ============================================================================
// Module      : riscv_trace_fifo
// Description : Register-array first-word fall-through FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module riscv_trace_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int c_ptr_w = $clog2(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w:0]   r_count;
    logic               w_wr;
    logic               w_rd;

    assign full     = (r_count == (c_ptr_w+1)'(DEPTH));
    assign empty    = (r_count == '0);
    assign count    = r_count;
    assign pop_data = r_mem[r_rd_ptr];

    assign w_rd = pop & ~empty;
    assign w_wr = push & (~full | w_rd);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_wr) begin
                r_mem[r_wr_ptr] <= push_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/riscv_retire_trace_buffer.sv
`default_nettype none
// ============================================================================
// Module      : riscv_retire_trace_buffer
// Description : Merges retirements with their data access into buffered trace records.
// Revision    : 1.0 - initial release
// ============================================================================
module riscv_retire_trace_buffer
    import riscv_trace_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int DEPTH   = 8,
    parameter int ORDER_W = 64
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 ret_valid,
    input  logic [31:0]          ret_instr,
    input  logic                 ret_trap,
    input  logic [XLEN-1:0]      ret_pc,
    input  logic [4:0]           ret_rd_addr,
    input  logic [XLEN-1:0]      ret_rd_wdata,
    input  logic                 dmem_valid,
    input  logic                 dmem_ready,
    input  logic                 dmem_write,
    input  logic [1:0]           dmem_size,
    input  logic [XLEN-1:0]      dmem_addr,
    input  logic [XLEN/8-1:0]    dmem_wstb,
    input  logic [XLEN-1:0]      dmem_wdata,
    input  logic [XLEN-1:0]      dmem_rdata,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_instr,
    output logic                 out_trap,
    output logic [XLEN-1:0]      out_pc,
    output logic [4:0]           out_rd_addr,
    output logic [XLEN-1:0]      out_rd_wdata,
    output logic [XLEN-1:0]      out_mem_addr,
    output logic [XLEN/8-1:0]    out_mem_rmask,
    output logic [XLEN/8-1:0]    out_mem_wmask,
    output logic [XLEN-1:0]      out_mem_data,
    output logic [ORDER_W-1:0]   out_order,
    output logic                 almost_full,
    output logic [31:0]          drop_count
);

    localparam int c_strb_w = XLEN / 8;
    localparam int c_off_w  = $clog2(c_strb_w);
    localparam int c_cnt_w  = $clog2(DEPTH) + 1;
    localparam int c_rec_w  = 32 + 1 + XLEN + 5 + XLEN + XLEN + 2 * c_strb_w + XLEN + ORDER_W;

    logic                 r_pend_valid;
    logic [XLEN-1:0]      r_pend_addr;
    logic [c_strb_w-1:0]  r_pend_rmask;
    logic [c_strb_w-1:0]  r_pend_wmask;
    logic [XLEN-1:0]      r_pend_data;
    logic [ORDER_W-1:0]   r_order;
    logic [31:0]          r_drop_count;

    logic                 w_hs;
    logic [c_strb_w-1:0]  w_acc_rmask;
    logic [c_strb_w-1:0]  w_acc_wmask;
    logic [XLEN-1:0]      w_acc_data;
    logic [XLEN-1:0]      w_mem_addr;
    logic [c_strb_w-1:0]  w_mem_rmask;
    logic [c_strb_w-1:0]  w_mem_wmask;
    logic [XLEN-1:0]      w_mem_data;
    logic [c_rec_w-1:0]   w_rec;
    logic [c_rec_w-1:0]   w_head;
    logic                 w_full;
    logic                 w_empty;
    logic [c_cnt_w-1:0]   w_count;
    logic                 w_pop;
    logic                 w_push;
    logic                 w_drop;

    assign w_hs        = dmem_valid & dmem_ready;
    assign w_acc_rmask = dmem_write ? '0
                       : c_strb_w'(size_to_mask(dmem_size, 3'(dmem_addr[c_off_w-1:0])));
    assign w_acc_wmask = dmem_write ? dmem_wstb : '0;
    assign w_acc_data  = dmem_write ? dmem_wdata : dmem_rdata;

    // A same-cycle handshake belongs to the retiring instruction and wins over pending.
    always_comb begin
        w_mem_addr  = '0;
        w_mem_rmask = '0;
        w_mem_wmask = '0;
        w_mem_data  = '0;
        if (w_hs) begin
            w_mem_addr  = dmem_addr;
            w_mem_rmask = w_acc_rmask;
            w_mem_wmask = w_acc_wmask;
            w_mem_data  = w_acc_data;
        end else if (r_pend_valid) begin
            w_mem_addr  = r_pend_addr;
            w_mem_rmask = r_pend_rmask;
            w_mem_wmask = r_pend_wmask;
            w_mem_data  = r_pend_data;
        end
    end

    assign w_rec = {ret_instr, ret_trap, ret_pc, ret_rd_addr, ret_rd_wdata,
                    w_mem_addr, w_mem_rmask, w_mem_wmask, w_mem_data, r_order};

    assign w_pop  = ~w_empty & out_ready;
    assign w_push = ret_valid & (~w_full | w_pop);
    assign w_drop = ret_valid & ~w_push;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_pend_valid <= 1'b0;
            r_pend_addr  <= '0;
            r_pend_rmask <= '0;
            r_pend_wmask <= '0;
            r_pend_data  <= '0;
        end else if (ret_valid) begin
            r_pend_valid <= 1'b0;
        end else if (w_hs) begin
            r_pend_valid <= 1'b1;
            r_pend_addr  <= dmem_addr;
            r_pend_rmask <= w_acc_rmask;
            r_pend_wmask <= w_acc_wmask;
            r_pend_data  <= w_acc_data;
        end
    end

    // Order advances on every retirement, dropped or not, so gaps reveal losses.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_order      <= '0;
            r_drop_count <= '0;
        end else begin
            if (ret_valid) begin
                r_order <= r_order + 1'b1;
            end
            if (w_drop && (r_drop_count != 32'hFFFF_FFFF)) begin
                r_drop_count <= r_drop_count + 1'b1;
            end
        end
    end

    riscv_trace_fifo #(
        .WIDTH (c_rec_w),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (w_push),
        .push_data (w_rec),
        .pop       (w_pop),
        .pop_data  (w_head),
        .full      (w_full),
        .empty     (w_empty),
        .count     (w_count)
    );

    assign {out_instr, out_trap, out_pc, out_rd_addr, out_rd_wdata,
            out_mem_addr, out_mem_rmask, out_mem_wmask, out_mem_data, out_order} = w_head;

    assign out_valid   = ~w_empty;
    assign almost_full = (w_count >= c_cnt_w'(DEPTH - 1));
    assign drop_count  = r_drop_count;

endmodule
`default_nettype wire

// File: tb/tb_riscv_retire_trace_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_riscv_retire_trace_buffer
// Description : Directed plus random bench against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_riscv_retire_trace_buffer;

    localparam int XLEN    = 32;
    localparam int DEPTH   = 8;
    localparam int ORDER_W = 64;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        ret_valid = 1'b0;
    logic [31:0] ret_instr = '0;
    logic        ret_trap = 1'b0;
    logic [31:0] ret_pc = '0;
    logic [4:0]  ret_rd_addr = '0;
    logic [31:0] ret_rd_wdata = '0;
    logic        dmem_valid = 1'b0;
    logic        dmem_ready = 1'b0;
    logic        dmem_write = 1'b0;
    logic [1:0]  dmem_size = '0;
    logic [31:0] dmem_addr = '0;
    logic [3:0]  dmem_wstb = '0;
    logic [31:0] dmem_wdata = '0;
    logic [31:0] dmem_rdata = '0;
    logic        out_ready = 1'b0;

    logic        out_valid;
    logic [31:0] out_instr;
    logic        out_trap;
    logic [31:0] out_pc;
    logic [4:0]  out_rd_addr;
    logic [31:0] out_rd_wdata;
    logic [31:0] out_mem_addr;
    logic [3:0]  out_mem_rmask;
    logic [3:0]  out_mem_wmask;
    logic [31:0] out_mem_data;
    logic [63:0] out_order;
    logic        almost_full;
    logic [31:0] drop_count;

    riscv_retire_trace_buffer #(.XLEN(XLEN), .DEPTH(DEPTH), .ORDER_W(ORDER_W)) dut (
        .clock(clock), .reset(reset),
        .ret_valid(ret_valid), .ret_instr(ret_instr), .ret_trap(ret_trap),
        .ret_pc(ret_pc), .ret_rd_addr(ret_rd_addr), .ret_rd_wdata(ret_rd_wdata),
        .dmem_valid(dmem_valid), .dmem_ready(dmem_ready), .dmem_write(dmem_write),
        .dmem_size(dmem_size), .dmem_addr(dmem_addr), .dmem_wstb(dmem_wstb),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_trap(out_trap), .out_pc(out_pc),
        .out_rd_addr(out_rd_addr), .out_rd_wdata(out_rd_wdata),
        .out_mem_addr(out_mem_addr), .out_mem_rmask(out_mem_rmask),
        .out_mem_wmask(out_mem_wmask), .out_mem_data(out_mem_data),
        .out_order(out_order), .almost_full(almost_full), .drop_count(drop_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] instr;
        logic        trap;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [31:0] wd;
        logic [31:0] ma;
        logic [3:0]  rm;
        logic [3:0]  wm;
        logic [31:0] md;
        logic [63:0] ord;
    } rec_t;

    rec_t        mq[$];
    rec_t        m_pend;
    bit          m_pend_v;
    logic [63:0] m_order;
    logic [31:0] m_drops;
    int          errors = 0;
    int          checks = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_out();
        chk("out_valid", out_valid, mq.size() > 0);
        chk("almost_full", almost_full, mq.size() >= DEPTH - 1);
        chk("drop_count", drop_count, m_drops);
        if (mq.size() > 0) begin
            chk("instr", out_instr, mq[0].instr);
            chk("trap", out_trap, mq[0].trap);
            chk("pc", out_pc, mq[0].pc);
            chk("rd_addr", out_rd_addr, mq[0].rd);
            chk("rd_wdata", out_rd_wdata, mq[0].wd);
            chk("mem_addr", out_mem_addr, mq[0].ma);
            chk("rmask", out_mem_rmask, mq[0].rm);
            chk("wmask", out_mem_wmask, mq[0].wm);
            chk("mem_data", out_mem_data, mq[0].md);
            chk("order", out_order, mq[0].ord);
        end
    endtask

    // Applies the retirement/access rules to the inputs in force, then clocks and checks.
    task automatic tick();
        rec_t acc;
        rec_t r;
        int   base;
        bit   hs;
        hs = dmem_valid && dmem_ready;
        acc = '{default: '0};
        acc.ma = dmem_addr;
        if (dmem_write) begin
            acc.wm = dmem_wstb;
            acc.md = dmem_wdata;
        end else begin
            base   = (1 << (1 << dmem_size)) - 1;
            acc.rm = 4'((base << dmem_addr[1:0]) & 'hF);
            acc.md = dmem_rdata;
        end
        if (mq.size() > 0 && out_ready) void'(mq.pop_front());
        if (ret_valid) begin
            r = '{default: '0};
            r.instr = ret_instr; r.trap = ret_trap; r.pc = ret_pc;
            r.rd = ret_rd_addr; r.wd = ret_rd_wdata; r.ord = m_order;
            if (hs) begin
                r.ma = acc.ma; r.rm = acc.rm; r.wm = acc.wm; r.md = acc.md;
            end else if (m_pend_v) begin
                r.ma = m_pend.ma; r.rm = m_pend.rm; r.wm = m_pend.wm; r.md = m_pend.md;
            end
            m_order = m_order + 1;
            if (mq.size() < DEPTH) mq.push_back(r);
            else if (m_drops != 32'hFFFF_FFFF) m_drops = m_drops + 1;
            m_pend_v = 0;
        end else if (hs) begin
            m_pend   = acc;
            m_pend_v = 1;
        end
        @(posedge clock);
        #1;
        check_out();
    endtask

    task automatic idle();
        ret_valid = 0; dmem_valid = 0; dmem_ready = 0; dmem_write = 0;
    endtask

    task automatic set_ret(input logic [31:0] pc);
        ret_valid = 1; ret_pc = pc; ret_instr = $urandom; ret_trap = 1'($urandom);
        ret_rd_addr = 5'($urandom); ret_rd_wdata = $urandom;
    endtask

    task automatic set_load(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
        dmem_valid = 1; dmem_ready = 1; dmem_write = 0; dmem_addr = a;
        dmem_size = sz; dmem_rdata = d; dmem_wstb = 4'($urandom); dmem_wdata = $urandom;
    endtask

    task automatic set_store(input logic [31:0] a, input logic [3:0] stb, input logic [31:0] d);
        dmem_valid = 1; dmem_ready = 1; dmem_write = 1; dmem_addr = a;
        dmem_size = 2'd0; dmem_wstb = stb; dmem_wdata = d; dmem_rdata = $urandom;
    endtask

    task automatic do_reset();
        idle();
        reset = 1;
        @(posedge clock);
        #1;
        reset = 0;
        mq.delete();
        m_pend_v = 0;
        m_order  = 0;
        m_drops  = 0;
        check_out();
    endtask

    initial begin
        m_pend_v = 0; m_order = 0; m_drops = 0;
        m_pend = '{default: '0};

        // Reset state: empty, counters clear, entry-0 fields zero.
        do_reset();
        chk("reset_instr", out_instr, 32'h0);
        chk("reset_order", out_order, 64'h0);

        // Load two cycles ahead of its retirement.
        out_ready = 0;
        set_load(32'h1000, 2'd2, 32'hDEAD_BEEF); tick();
        idle(); tick();
        set_ret(32'h80); tick();
        chk("ld_addr", out_mem_addr, 32'h1000);
        chk("ld_rmask", out_mem_rmask, 4'hF);
        chk("ld_wmask", out_mem_wmask, 4'h0);
        chk("ld_data", out_mem_data, 32'hDEAD_BEEF);
        chk("ld_order", out_order, 64'd0);

        // Store concurrent with retirement, then a retirement with no access.
        idle(); set_ret(32'h84); set_store(32'h1003, 4'h8, 32'h1122_3344); tick();
        idle(); set_ret(32'h88); tick();
        idle(); out_ready = 1; tick();
        chk("st_wmask", out_mem_wmask, 4'h8);
        chk("st_rmask", out_mem_rmask, 4'h0);
        chk("st_data", out_mem_data, 32'h1122_3344);
        tick();
        chk("noacc_addr", out_mem_addr, 32'h0);
        chk("noacc_rmask", out_mem_rmask, 4'h0);
        chk("noacc_data", out_mem_data, 32'h0);
        tick();

        // Half load at 0x1002, then last-of-two-loads wins.
        set_load(32'h1002, 2'd1, 32'hCAFE_0000); tick();
        idle(); set_ret(32'h8C); tick();
        chk("half_rmask", out_mem_rmask, 4'hC);
        idle(); set_load(32'h2000, 2'd2, 32'hAAAA_AAAA); tick();
        set_load(32'h2005, 2'd0, 32'hBBBB_BBBB); tick();
        idle(); set_ret(32'h90); tick();
        chk("last_addr", out_mem_addr, 32'h2005);
        chk("last_rmask", out_mem_rmask, 4'h2);
        idle(); tick();

        // Ten retirements against a stalled sink.
        do_reset();
        out_ready = 0;
        for (int i = 0; i < 10; i++) begin
            set_ret(32'h100 + 32'(4 * i)); tick();
            if (i == 5) chk("af_after6", almost_full, 1'b0);
            if (i == 6) chk("af_after7", almost_full, 1'b1);
        end
        chk("drops_10", drop_count, 32'd2);
        idle(); out_ready = 1;
        for (int i = 0; i < 8; i++) begin
            chk("drain_order", out_order, 64'(i));
            tick();
        end
        chk("drained", out_valid, 1'b0);
        out_ready = 0; set_ret(32'h200); tick();
        chk("order_after_drop", out_order, 64'd10);

        // Fill, then push and pop together while full.
        for (int i = 0; i < 7; i++) begin
            set_ret(32'h300 + 32'(4 * i)); tick();
        end
        out_ready = 1; set_ret(32'h400); tick();
        chk("full_pushpop_drops", drop_count, 32'd2);
        out_ready = 0; set_ret(32'h404); tick();
        chk("full_drop", drop_count, 32'd3);

        // Reset with entries queued.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            set_ret(32'h500 + 32'(4 * i)); tick();
        end
        do_reset();
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_drops", drop_count, 32'd0);
        set_ret(32'h600); tick();
        chk("rst_order", out_order, 64'd0);
        idle();

        // Random traffic: fast sink, then a slow sink to exercise full/drop.
        for (int i = 0; i < 600; i++) begin
            ret_valid = 1'($urandom);
            ret_instr = $urandom; ret_trap = 1'($urandom); ret_pc = $urandom;
            ret_rd_addr = 5'($urandom); ret_rd_wdata = $urandom;
            dmem_valid = 1'($urandom); dmem_ready = 1'($urandom);
            dmem_write = 1'($urandom); dmem_size = 2'($urandom_range(0, 2));
            dmem_addr = $urandom; dmem_wstb = 4'($urandom);
            dmem_wdata = $urandom; dmem_rdata = $urandom;
            out_ready = (i < 300) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
